// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 scan controller: FSM state encoding and channel indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hub75_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } state_t;

   localparam int CH_R0  = 0;
   localparam int CH_G0  = 1;
   localparam int CH_B0  = 2;
   localparam int CH_R1  = 3;
   localparam int CH_G1  = 4;
   localparam int CH_B1  = 5;
   localparam int NUM_CH = 6;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter timing the oe-low window of one bit plane (BASE_OE << plane cycles).
// Latency: done asserts in the last cycle of the window, counted from the cycle after load.
// Backpressure: none; free-running once loaded.
module hub75_bcm_timer
   import hub75_pkg::*;
#(
   parameter int BITS    = 4,
   parameter int BASE_OE = 4,
   parameter int PW      = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [PW-1:0] plane,
   output logic          done
);

   localparam int TW = $clog2(BASE_OE) + BITS;

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= TW'(BASE_OE) << plane;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == TW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel scanner: fetches one row/plane from the framebuffer, shifts it out, latches, then BCM-displays.
// Latency: 2*WIDTH+3+(BASE_OE<<plane) cycles per row-plane; all outputs registered.
// Backpressure: none; en is honoured only in IDLE and at the end of a display window.
module hub75_scan_ctrl
   import hub75_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ROWS    = 8,
   parameter int BITS    = 4,
   parameter int BASE_OE = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  en,
   output logic                                  fb_rd_en,
   output logic [$clog2(ROWS)+$clog2(WIDTH)-1:0] fb_addr,
   input  logic [6*BITS-1:0]                     fb_rdata,
   output logic [5:0]                            rgb,
   output logic [$clog2(ROWS)-1:0]               a,
   output logic                                  oe,
   output logic                                  lat,
   output logic                                  oclk,
   output logic                                  frame_start
);

   localparam int RW  = $clog2(ROWS);
   localparam int CLW = $clog2(WIDTH);
   localparam int PW  = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int CW  = CLW + 2;
   localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * WIDTH);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [RW-1:0] row, row_nx;
   logic [PW-1:0] plane, plane_nx;
   logic          tmr_load, tmr_done;
   logic          rd_nx;
   logic [NUM_CH-1:0]           rgb_nx;
   logic [NUM_CH-1:0][BITS-1:0] chan;

   hub75_bcm_timer #(
      .BITS    (BITS),
      .BASE_OE (BASE_OE),
      .PW      (PW)
   ) u_bcm_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .plane (plane),
      .done  (tmr_done)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      row_nx   = row;
      plane_nx = plane;
      tmr_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
               state_nx = ST_SHIFT;
               cnt_nx   = '0;
               row_nx   = '0;
               plane_nx = '0;
            end
         end
         ST_SHIFT: begin
            if (cnt == SHIFT_LAST) state_nx = ST_BLANK;
            else                   cnt_nx   = cnt + 1'b1;
         end
         ST_BLANK: state_nx = ST_LATCH;
         ST_LATCH: begin
            state_nx = ST_DISPLAY;
            tmr_load = 1'b1;
         end
         ST_DISPLAY: begin
            // the oe window always runs to completion before en is looked at
            if (tmr_done) begin
               if (en) begin
                  state_nx = ST_SHIFT;
                  cnt_nx   = '0;
                  if (plane == PW'(BITS - 1)) begin
                     plane_nx = '0;
                     row_nx   = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
                  end else begin
                     plane_nx = plane + 1'b1;
                  end
               end else begin
                  state_nx = ST_IDLE;
                  row_nx   = '0;
                  plane_nx = '0;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign chan  = fb_rdata;
   assign rd_nx = (state_nx == ST_SHIFT) && !cnt_nx[0] && (cnt_nx < SHIFT_LAST);

   always_comb begin
      rgb_nx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         rgb_nx[k] = chan[k][plane];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         row   <= '0;
         plane <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         row   <= row_nx;
         plane <= plane_nx;
      end
   end

   // Outputs are registered from next-state values so each lands in its own cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_rd_en    <= 1'b0;
         fb_addr     <= '0;
         rgb         <= '0;
         a           <= '0;
         oe          <= 1'b1;
         lat         <= 1'b0;
         oclk        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         fb_rd_en <= rd_nx;
         if (rd_nx) fb_addr <= {row_nx, cnt_nx[CLW:1]};
         if (fb_rd_en) rgb <= rgb_nx;
         oclk <= (state_nx == ST_SHIFT) && !cnt_nx[0] && (cnt_nx != '0);
         lat  <= (state_nx == ST_LATCH);
         if (state_nx == ST_LATCH) a <= row;
         oe <= (state_nx != ST_DISPLAY);
         frame_start <= (state_nx == ST_SHIFT) && (state != ST_SHIFT) &&
                        (row_nx == '0) && (plane_nx == '0);
      end
   end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: expected panel events are queued by the stimulus and
// popped by a monitor watching oclk/lat/oe/frame_start edges.
module tb_hub75_scan_ctrl;

   localparam int W   = 32;
   localparam int R   = 8;
   localparam int B   = 4;
   localparam int BOE = 4;
   localparam int FRAME = 2624;

   localparam int EV_FS  = 0;
   localparam int EV_CLK = 1;
   localparam int EV_LAT = 2;
   localparam int EV_OE  = 3;
   localparam int DC     = -1;

   // {rgb, a, oe, lat, oclk, fb_rd_en, fb_addr, frame_start}
   localparam logic [21:0] RST_VEC = {6'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        fb_rd_en;
   logic [7:0]  fb_addr;
   logic [23:0] fb_rdata;
   logic [5:0]  rgb;
   logic [2:0]  a;
   logic        oe;
   logic        lat;
   logic        oclk;
   logic        frame_start;

   ev_t sb[$];
   int  total = 0;
   int  bad   = 0;

   hub75_scan_ctrl #(
      .WIDTH   (W),
      .ROWS    (R),
      .BITS    (B),
      .BASE_OE (BOE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .fb_rd_en    (fb_rd_en),
      .fb_addr     (fb_addr),
      .fb_rdata    (fb_rdata),
      .rgb         (rgb),
      .a           (a),
      .oe          (oe),
      .lat         (lat),
      .oclk        (oclk),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Framebuffer contents: col*0x111 with the row number in the B1 channel.
   function automatic logic [23:0] fb_word(int row, int col);
      return 24'((col * 32'h111) | (row << 20));
   endfunction

   always_comb begin
      fb_rdata = 24'h5A5A5A;
      if (fb_rd_en) fb_rdata = fb_word(int'(fb_addr[7:5]), int'(fb_addr[4:0]));
   end

   function automatic int exp_rgb(int row, int plane, int col);
      logic [23:0] d;
      logic [23:0] sh;
      int r;
      d = fb_word(row, col);
      r = 0;
      for (int k = 0; k < 6; k++) begin
         sh = d >> (k * 4 + plane);
         if (sh[0]) r = r | (1 << k);
      end
      return r;
   endfunction

   function automatic string ev_name(int kind);
      case (kind)
         EV_FS:   return "frame_start";
         EV_CLK:  return "oclk_rgb";
         EV_LAT:  return "lat_a";
         default: return "oe_width";
      endcase
   endfunction

   function automatic logic [21:0] outs();
      return {rgb, a, oe, lat, oclk, fb_rd_en, fb_addr, frame_start};
   endfunction

   task automatic push(int kind, int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic push_rp(int row, int plane, int fs_val, int ncols);
      if (row == 0 && plane == 0) push(EV_FS, fs_val);
      for (int c = 0; c < ncols; c++) push(EV_CLK, exp_rgb(row, plane, c));
      if (ncols == W) begin
         push(EV_LAT, row);
         push(EV_OE, BOE << plane);
      end
   endtask

   task automatic chk(string name, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic got_ev(int kind, int val);
      ev_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s: got %0d expected no event at %0t", ev_name(kind), val, $time);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || (e.val != DC && e.val != val)) begin
            bad++;
            $display("FAIL %s: got %s=%0d expected %s=%0d at %0t",
                     ev_name(e.kind), ev_name(kind), val, ev_name(e.kind), e.val, $time);
         end
      end
   endtask

   task automatic wait_size(int n, int budget, string name);
      int cycles;
      cycles = 0;
      while (sb.size() > n && cycles < budget) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      if (sb.size() > n) begin
         total++;
         bad++;
         $display("FAIL timeout_%s: got %0d events pending expected %0d", name, sb.size(), n);
         sb.delete();
      end
   endtask

   // Monitor: turns output edges into events and checks them against the queue.
   initial begin
      int   cyc;
      int   last_fs;
      int   oe_w;
      logic p_oclk, p_lat, p_oe;
      cyc = 0; last_fs = -1; oe_w = 0;
      p_oclk = 1'b0; p_lat = 1'b0; p_oe = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            oe_w = 0; p_oclk = 1'b0; p_lat = 1'b0; p_oe = 1'b1;
         end else begin
            if (lat && oclk) begin
               total++; bad++;
               $display("FAIL lat_oclk_overlap: got lat=1 oclk=1 expected never both at %0t", $time);
            end
            if (!oe && (lat || oclk || fb_rd_en)) begin
               total++; bad++;
               $display("FAIL oe_overlap: got oe=0 lat=%0b oclk=%0b rd=%0b expected oe=1 at %0t",
                        lat, oclk, fb_rd_en, $time);
            end
            if (!oe) oe_w++;
            else if (!p_oe) begin
               got_ev(EV_OE, oe_w);
               oe_w = 0;
            end
            if (frame_start) begin
               got_ev(EV_FS, (last_fs < 0) ? -2 : cyc - last_fs);
               last_fs = cyc;
            end
            if (lat && !p_lat) got_ev(EV_LAT, int'(a));
            if (oclk && !p_oclk) got_ev(EV_CLK, int'(rgb));
            p_oclk = oclk; p_lat = lat; p_oe = oe;
         end
      end
   end

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      #1 rst_n = 1'b0;

      repeat (3) begin
         @(negedge clk);
         chk("reset_hold", int'(outs()), int'(RST_VEC));
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("idle_en0", int'(outs()), int'(RST_VEC));
      end

      // Two full frames, then row 0 planes 0..2 of a third; en drops inside plane 2's window.
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < R; r++)
            for (int p = 0; p < B; p++)
               push_rp(r, p, (f == 0) ? DC : FRAME, W);
      for (int p = 0; p < 3; p++) push_rp(0, p, FRAME, W);
      @(negedge clk);
      en = 1'b1;
      wait_size(1, 3 * FRAME + 500, "frames");
      repeat (4) @(negedge clk);
      en = 1'b0;
      wait_size(0, 100, "en_drop");
      repeat (10) @(negedge clk);
      chk("idle_after_drop_oe", int'(oe), 1);
      chk("idle_after_drop_rd", int'(fb_rd_en), 0);

      // Re-enable, then hit async reset inside the SHIFT of plane 1 (column 5 read cycle).
      push_rp(0, 0, DC, W);
      push_rp(0, 1, DC, 5);
      en = 1'b1;
      wait_size(0, 300, "reenable");
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_shift", int'(outs()), int'(RST_VEC));
      @(negedge clk);
      chk("rst_mid_shift_hold", int'(outs()), int'(RST_VEC));
      @(negedge clk);
      push_rp(0, 0, DC, W);
      push_rp(0, 1, DC, W);
      rst_n = 1'b1;
      wait_size(1, 300, "post_reset");
      en = 1'b0;
      wait_size(0, 100, "post_reset_stop");
      repeat (5) @(negedge clk);
      chk("final_idle_oe", int'(oe), 1);
      chk("final_idle_oclk", int'(oclk), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Scan controller for the HUB75-style RGB LED panel on the up5k display board. It reads pixel words from the framebuffer over a one-cycle-latency read port and shifts one row of one bit plane out on `rgb`/`oclk`. It then latches the row and drives `oe` for a binary-weighted time, giving bit-plane (BCM) brightness. It sits between the framebuffer RAM (written by the SPI front end) and the panel header pins.

## Interface
- `WIDTH`, 32: panel columns per row, power of two.
- `ROWS`, 8: scan rows (address lines = `$clog2(ROWS)`); each row drives an upper and a lower half-panel line.
- `BITS`, 4: colour depth per channel (bit planes), 1..8.
- `BASE_OE`, 4: display cycles for plane 0; plane p displays `BASE_OE << p` cycles; ≥ 1.

Ports:
- `clk` in 1: panel clock (PLL output).
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scanning enable.
- `fb_rd_en` out 1: framebuffer read strobe.
- `fb_addr` out `$clog2(ROWS)+$clog2(WIDTH)`: `{row, col}`.
- `fb_rdata` in `6*BITS`: data for the address read on the previous cycle. Channel k occupies bits `[k*BITS +: BITS]`, with k = 0..5 = R0,G0,B0,R1,G1,B1.
- `rgb` out 6: panel data; `rgb[k]` = plane bit of channel k.
- `a` out `$clog2(ROWS)`: row address.
- `oe` out 1: output enable, active low.
- `lat` out 1: latch, active high.
- `oclk` out 1: shift clock, data sampled by panel on rising edge.
- `frame_start` out 1: one-cycle pulse when row 0 / plane 0 begins shifting.

## Operation
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- Reset values: `rgb`=0, `a`=0, `oe`=1, `lat`=0, `oclk`=0, `fb_rd_en`=0, `fb_addr`=0, `frame_start`=0. State is IDLE; row and plane counters are 0.
- IDLE: `oe`=1. When `en`=1, go to SHIFT for row 0, plane 0 and pulse `frame_start`.
- SHIFT: fetch and shift columns 0..WIDTH-1 of the current row. Emit the current plane bit of each channel. `oe` stays 1.
- BLANK: 1 cycle, `oe`=1, `oclk`=0.
- LATCH: 1 cycle, `lat`=1. `a` takes the current row at the same edge at which `lat` rises.
- DISPLAY: `oe`=0 for `BASE_OE<<plane` cycles. At the end:
  - Next plane; after plane BITS-1, plane returns to 0 and row increments.
  - After row ROWS-1, row wraps to 0 and `frame_start` pulses with the first SHIFT cycle.
- `en` is sampled only at the end of DISPLAY and in IDLE. If `en`=0 at the end of DISPLAY, go to IDLE and reset the row and plane counters. Deasserting `en` mid-row never truncates an `oe` pulse.
- Async reset mid-operation: all outputs return to reset values immediately; `oe`=1 blanks the panel.
- Row counter and plane counter wrap modulo ROWS and BITS. `BASE_OE<<plane` uses a counter of width `$clog2(BASE_OE)+BITS`.

## Timing
- Column c occupies SHIFT cycles 1+2c and 2+2c, where cycle 0 is the SHIFT entry cycle.
- `fb_rd_en`=1 with `fb_addr={row,c}` in cycle 2c; only even cycles < 2·WIDTH read.
- `rgb` registers `fb_rdata` plane bits at the end of cycle 2c; it is valid from cycle 2c+1, with `oclk`=0.
- `oclk`=1 in cycle 2c+2; `rgb` is held stable through it.
- SHIFT length is 2·WIDTH+1 cycles.
- Per row-plane cycles: 2·WIDTH+3+`BASE_OE<<p`.
- Frame length: ROWS·(BITS·(2·WIDTH+3) + BASE_OE·(2^BITS−1)). Defaults give 2624 cycles.
- `lat` and `oclk` are never high in the same cycle. `oe`=0 never overlaps SHIFT or LATCH.

## Structure
- Shared package `hub75_pkg`: the state enum and channel index constants (R0..B1 = 0..5).
- One natural sub-module, `hub75_bcm_timer`: a loadable down-counter for the DISPLAY duration. It takes plane and BASE_OE and outputs `done`.
- Top level `hub75_scan_ctrl` holds the FSM, the column, row and plane counters, and the output registers. All outputs are registered.

## Test plan
- Reset: hold `rst_n`=0, then release with `en`=0. Required: `oe`=1 and all other outputs 0 indefinitely. `fb_rd_en` never rises.
- Single row-plane (defaults, fb model returns `fb_rdata`=col·0x111 masked): required are exactly 32 `oclk` rising edges, `rgb` matching plane-0 bits per column, then 1 BLANK cycle, a `lat` pulse with `a`=0, and `oe`=0 for 4 cycles.
- BCM weights: measure `oe`-low widths for row 0. Required: 4, 8, 16, 32 cycles, then row 1 (`a`=1) starts.
- Frame wrap: run 2 frames. Required: `frame_start` pulses exactly 2624 cycles apart, and `a` sequence 0..7 repeats.
- Enable drop mid-DISPLAY of plane 2: required is a full 16-cycle `oe` pulse, then IDLE with `oe`=1. Re-enable restarts at row 0 / plane 0 with `frame_start`.
- Async reset asserted mid-SHIFT: outputs return to reset values in the same cycle. After release, the sequence restarts at row 0 / plane 0.
